// File: rtl/cnn_pkg.sv
// Shared definitions for the MNIST CNN pipeline.
// Holds the fully-connected output score format and the class-index format.
// Downstream stages take their parameter defaults from this package.
package cnn_pkg;

    // Width of a signed class score coming out of the FC layer.
    localparam int FC_DATA_BITS   = 12;
    // Number of output classes (digits 0..9).
    localparam int NUM_CLASSES    = 10;
    // Width of a class index; 2**CLASS_IDX_BITS must cover NUM_CLASSES.
    localparam int CLASS_IDX_BITS = 4;

    typedef logic signed [FC_DATA_BITS-1:0] score_t;
    typedef logic [CLASS_IDX_BITS-1:0]      class_idx_t;

endpackage : cnn_pkg

// File: rtl/argmax_comparator.sv
// argmax_comparator
// Final classification stage of the MNIST CNN. Accepts CLASS_NUM signed
// scores serially (the k-th valid beat of an image is class k) and reports
// the index of the largest one. Ties go to the lowest class index.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   valid_in   data_in carries a score this cycle
//   data_in    signed class score
//   decision   index of the max score of the last completed image (held)
//   valid_out  one-cycle pulse, the cycle after the last score is sampled
//   max_value  winning score, registered with decision
//              (present only when ARGMAX_MAXVAL_EN is defined)
//
// Build option: define ARGMAX_MAXVAL_EN to add the max_value output.
module argmax_comparator
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = FC_DATA_BITS,
    parameter int CLASS_NUM = NUM_CLASSES,
    parameter int IDX_BITS  = CLASS_IDX_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] data_in,
    output logic [IDX_BITS-1:0]         decision,
    output logic                        valid_out
`ifdef ARGMAX_MAXVAL_EN
    ,
    output logic signed [DATA_BITS-1:0] max_value
`endif
);

    localparam logic signed [DATA_BITS-1:0] MOST_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};
    localparam logic [IDX_BITS-1:0]         ZERO_IDX = {IDX_BITS{1'b0}};
    localparam logic [IDX_BITS-1:0]         ONE_IDX  = {{(IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0]         LAST_CNT = IDX_BITS'(CLASS_NUM - 1);

    logic [IDX_BITS-1:0]         cnt_q, cnt_d;
    logic [IDX_BITS-1:0]         idx_q, idx_d;
    logic signed [DATA_BITS-1:0] max_q, max_d;
    logic [IDX_BITS-1:0]         decision_q, decision_d;
    logic                        valid_q, valid_d;
`ifdef ARGMAX_MAXVAL_EN
    logic signed [DATA_BITS-1:0] maxval_q, maxval_d;
`endif

    // The current beat takes the lead if it opens the image or strictly beats
    // the running max; strictness is what makes the lowest index win ties.
    logic take_s;
    assign take_s = (cnt_q == ZERO_IDX) || (data_in > max_q);

    // Next-state logic: running max/index update and end-of-image decision.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        max_d      = max_q;
        decision_d = decision_q;
        valid_d    = 1'b0;
`ifdef ARGMAX_MAXVAL_EN
        maxval_d   = maxval_q;
`endif
        if (valid_in) begin
            if (cnt_q == LAST_CNT) begin
                // Winner includes the current beat; then re-arm for the next image.
                decision_d = take_s ? cnt_q : idx_q;
                valid_d    = 1'b1;
`ifdef ARGMAX_MAXVAL_EN
                maxval_d   = take_s ? data_in : max_q;
`endif
                cnt_d      = ZERO_IDX;
                idx_d      = ZERO_IDX;
                max_d      = MOST_NEG;
            end else begin
                if (take_s) begin
                    max_d = data_in;
                    idx_d = cnt_q;
                end else begin
                    max_d = max_q;
                    idx_d = idx_q;
                end
                cnt_d = cnt_q + ONE_IDX;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= ZERO_IDX;
            idx_q      <= ZERO_IDX;
            max_q      <= MOST_NEG;
            decision_q <= ZERO_IDX;
            valid_q    <= 1'b0;
`ifdef ARGMAX_MAXVAL_EN
            maxval_q   <= {DATA_BITS{1'b0}};
`endif
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            decision_q <= decision_d;
            valid_q    <= valid_d;
`ifdef ARGMAX_MAXVAL_EN
            maxval_q   <= maxval_d;
`endif
        end
    end

    assign decision  = decision_q;
    assign valid_out = valid_q;
`ifdef ARGMAX_MAXVAL_EN
    assign max_value = maxval_q;
`endif

endmodule : argmax_comparator

// File: tb/tb_argmax_comparator.sv
// Self-checking bench for argmax_comparator. A queue-based reference model
// collects each image's scores and picks the winner with a plain search.
// Define ARGMAX_MAXVAL_EN to also check the max_value output.
module tb_argmax_comparator;

    localparam int DB = 12;
    localparam int CN = 10;
    localparam int IB = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 valid_in;
    logic signed [DB-1:0] data_in;
    logic [IB-1:0]        decision;
    logic                 valid_out;
`ifdef ARGMAX_MAXVAL_EN
    logic signed [DB-1:0] max_value;
`endif

    argmax_comparator #(.DATA_BITS(DB), .CLASS_NUM(CN), .IDX_BITS(IB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .decision  (decision),
        .valid_out (valid_out)
`ifdef ARGMAX_MAXVAL_EN
        ,
        .max_value (max_value)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // reference model state
    int                   img_q[$];
    logic [IB-1:0]        exp_dec;
    logic                 exp_valid;
    logic signed [DB-1:0] exp_max;

    logic signed [DB-1:0] img[CN];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic step(input logic v, input logic signed [DB-1:0] d, input logic r);
        int best;
        valid_in = v;
        data_in  = d;
        rst_n    = r;
        @(posedge clk);
        exp_valid = 1'b0;
        if (!r) begin
            img_q.delete();
            exp_dec = '0;
`ifdef ARGMAX_MAXVAL_EN
            exp_max = '0;
`endif
        end else if (v) begin
            img_q.push_back(int'(d));
            if (img_q.size() == CN) begin
                best = 0;
                for (int i = 1; i < CN; i++)
                    if (img_q[i] > img_q[best]) best = i;
                exp_dec   = IB'(best);
                exp_max   = DB'(img_q[best]);
                exp_valid = 1'b1;
                img_q.delete();
            end
        end
        @(negedge clk);
        chk("valid_out", valid_out, exp_valid);
        chk("decision", decision, exp_dec);
`ifdef ARGMAX_MAXVAL_EN
        chk("max_value", max_value, exp_max);
`endif
        if (valid_out === 1'b1) pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DB'($urandom), 1'b1);
    endtask

    // Feed img[] with random idle gaps (0..maxgap) between beats, none after the last.
    task automatic feed(input int maxgap);
        for (int k = 0; k < CN; k++) begin
            step(1'b1, img[k], 1'b1);
            if (k != CN - 1 && maxgap > 0) idle($urandom_range(0, maxgap));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        exp_dec   = '0;
        exp_valid = 1'b0;
        exp_max   = '0;
        @(negedge clk);

        // reset state
        step(1'b0, 12'sd0, 1'b0);
        step(1'b1, 12'sd100, 1'b0);
        chk("rst_decision", decision, 32'sd0);
        chk("rst_valid", valid_out, 32'sd0);
        idle(2);

        // ascending scores, consecutive cycles
        for (int k = 0; k < CN; k++) img[k] = DB'(k);
        feed(0);
        chk("asc_valid", valid_out, 32'sd1);
        chk("asc_dec", decision, 32'sd9);
        idle(1);
        chk("asc_pulse_end", valid_out, 32'sd0);
        chk("asc_hold", decision, 32'sd9);

        // mixed scores with random gaps
        img = '{-12'sd5, 12'sd12, 12'sd7, 12'sd300, -12'sd2048, 12'sd299, 12'sd0, 12'sd1, 12'sd2, 12'sd3};
        feed(3);
        chk("mixed_dec", decision, 32'sd3);
`ifdef ARGMAX_MAXVAL_EN
        chk("mixed_max", max_value, 32'sd300);
`endif
        idle(2);

        // ties: lowest index wins
        img = '{12'sd50, 12'sd80, 12'sd80, -12'sd1, 12'sd80, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd80};
        feed(1);
        chk("tie_dec", decision, 32'sd1);
        idle(1);
        for (int k = 0; k < CN; k++) img[k] = -12'sd2048;
        feed(0);
        chk("allneg_min_dec", decision, 32'sd0);
        idle(1);

        // all negative
        img = '{-12'sd100, -12'sd3, -12'sd50, -12'sd7, -12'sd2047, -12'sd9, -12'sd4, -12'sd3, -12'sd200, -12'sd8};
        feed(2);
        chk("neg_dec", decision, 32'sd1);
        idle(1);

        // reset mid-image, then full image with max at class 7
        for (int k = 0; k < 6; k++) step(1'b1, 12'sd900, 1'b1);
        step(1'b1, 12'sd900, 1'b0);
        chk("midrst_dec", decision, 32'sd0);
        img = '{12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7, 12'sd500, 12'sd8, 12'sd9};
        pulses = 0;
        feed(1);
        chk("midrst_pulses", pulses, 32'sd1);
        chk("midrst_after_dec", decision, 32'sd7);
        idle(1);

        // back-to-back images, no idle cycle between them
        pulses = 0;
        img = '{12'sd0, 12'sd1, 12'sd2, 12'sd3, 12'sd40, 12'sd5, 12'sd6, 12'sd7, 12'sd8, 12'sd9};
        feed(0);
        chk("b2b_first_dec", decision, 32'sd4);
        img = '{12'sd0, 12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7, 12'sd80, 12'sd9};
        feed(0);
        chk("b2b_second_dec", decision, 32'sd8);
        chk("b2b_pulses", pulses, 32'sd2);
        idle(2);

        // randomized images with gaps, tie-prone values and occasional resets
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < CN; k++) begin
                if ($urandom_range(0, 40) == 0)
                    step(1'b0, 12'sd0, 1'b0);
                if (n % 3 == 0)
                    step(1'b1, DB'($urandom_range(0, 3)) - 12'sd2, 1'b1);
                else
                    step(1'b1, DB'($urandom), 1'b1);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_argmax_comparator

// File: doc/argmax_comparator.md
Name: argmax_comparator

Overview:
- Final classification stage of the MNIST CNN pipeline.
- Sits after the fully-connected layer and takes its CLASS_NUM signed class scores serially, one per valid_in beat.
- Outputs the 4-bit index of the largest score, with a one-cycle valid_out pulse.
- Restarts automatically for the next image.

Parameters:
- DATA_BITS, 12, width of the signed two's-complement score input.
- CLASS_NUM, 10, number of scores per image (classes 0..CLASS_NUM-1).
- IDX_BITS, 4, width of the class index/counter; must satisfy 2**IDX_BITS >= CLASS_NUM.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- valid_in  input  1  data_in holds a valid score this cycle.
- data_in  input  DATA_BITS  signed class score. The k-th valid beat of an image is class k.
- decision  output  IDX_BITS  index of the maximum score of the last completed image.
- valid_out  output  1  one-cycle pulse marking a new decision.

Behaviour:
- Reset: synchronous, sampled on rising clk while rst_n=0. Resets the following:
  - decision=0, valid_out=0.
  - class counter cnt=0.
  - running max = most negative DATA_BITS value.
  - running index = 0.
- Reset mid-image discards the partial image; the next valid beat is class 0.
- Beats with valid_in=0 are ignored: no state change, and valid_out=0 that cycle. Gaps between valid beats of any length are allowed.
- On each valid beat with cnt < CLASS_NUM-1:
  - If cnt==0 (first beat), max<=data_in and idx<=0 unconditionally.
  - Otherwise, if data_in > max (signed, strict), then max<=data_in and idx<=cnt.
  - cnt<=cnt+1.
- Final beat (cnt==CLASS_NUM-1 with valid_in=1):
  - Compute the winner including the current beat, using the same strict-greater rule.
  - Register decision <= winner and valid_out<=1.
  - Then cnt<=0, max<=most negative, idx<=0.
- Latency: valid_out is high in the cycle immediately after the edge that sampled the last score.
- valid_out lasts exactly one cycle. decision holds its value until the next completed image or reset.
- Ties: the lowest class index wins, because replacement requires strictly greater.
- All-negative scores are handled correctly via signed compare. The most-negative value is a legal score; class 0 wins if all scores are equal.
- Back-to-back images: a valid beat in the same cycle valid_out is high is class 0 of the next image.
- No backpressure; the downstream consumer must accept each valid_out pulse.
- Internal state: cnt (IDX_BITS), max (DATA_BITS signed), idx (IDX_BITS). No FSM beyond the counter.

Optional Feature:
- ARGMAX_MAXVAL_EN defined:
  - Adds output port max_value, DATA_BITS signed.
  - max_value is registered together with decision and holds the winning score.
  - Reset value is 0. It updates only when valid_out pulses.
- Not defined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cnn_pkg holds:
  - localparams FC_DATA_BITS=12, NUM_CLASSES=10, CLASS_IDX_BITS=4.
  - typedef score_t (signed logic [FC_DATA_BITS-1:0]).
  - typedef class_idx_t (logic [CLASS_IDX_BITS-1:0]).
- Module parameter defaults are taken from cnn_pkg.
- Single flat module; no sub-module is warranted.

Test Plan:
- Ascending scores 0,1,...,9 on consecutive cycles -> one cycle after the 10th beat, valid_out=1 for exactly one cycle and decision=9.
- Scores {-5,12,7,300,-2048,299,0,1,2,3} with random 0-3 cycle gaps -> decision=3. With ARGMAX_MAXVAL_EN: max_value=300.
- Ties {50,80,80,-1,80,0,0,0,0,80} -> decision=1. All equal to -2048 -> decision=0.
- All negative {-100,-3,-50,-7,-2047,-9,-4,-3,-200,-8} -> decision=1 (first -3 wins).
- Reset after 6 beats, then a full image with max at class 7 -> decision=7, and no valid_out between reset and completion.
- Two images back-to-back with no idle cycle (max at 4, then max at 8) -> valid_out pulses twice, giving decision 4 then 8. decision holds 4 until the second pulse.
